// File: rtl/count_cmd_pkg.sv
// Shared types and constants for the count commander block.
package count_cmd_pkg;

  localparam int TBL_DEPTH = 8;
  localparam int TBL_AW    = 3;
  localparam int DW        = 4;
  localparam int BLANK     = 3;
  localparam int TIMEOUT   = 24;
  localparam int TMO_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/count_cmd_if.sv
// Control, configuration and responder handshake bundle for count_commander.
interface count_cmd_if;
  import count_cmd_pkg::*;

  logic              start;
  logic              loop_en;
  logic              cfg_we;
  logic [TBL_AW-1:0] cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic [TBL_AW-1:0] cfg_last;
  logic              ini;
  logic [DW-1:0]     ent;
  logic [DW-1:0]     sal;
  logic              busy;
  logic              done;
  logic              err;
  logic [TBL_AW-1:0] step_idx;

  modport master (
    output start, loop_en, cfg_we, cfg_addr, cfg_data, cfg_last, sal,
    input  ini, ent, busy, done, err, step_idx
  );

  modport slave (
    input  start, loop_en, cfg_we, cfg_addr, cfg_data, cfg_last, sal,
    output ini, ent, busy, done, err, step_idx
  );

endinterface

// File: rtl/count_cmd_table.sv
// 8x4 target table: one synchronous write port, one combinational read port.
module count_cmd_table
  import count_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [TBL_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [TBL_AW-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [TBL_DEPTH];

  // Storage update: reset clears every entry, otherwise commit the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/count_commander.sv
// Sequencer that issues table targets to a counting responder and waits for
// the responder's count to reach each target, with blanking and timeout.
module count_commander
  import count_cmd_pkg::*;
(
  input logic        clk,
  input logic        rst,
  count_cmd_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [TBL_AW-1:0] step_q;
  logic [TBL_AW-1:0] step_nxt;
  logic [TBL_AW-1:0] last_q;
  logic [TBL_AW-1:0] last_nxt;
  logic              loop_q;
  logic              loop_nxt;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_nxt;
  logic [DW-1:0]     sal_meta;
  logic [DW-1:0]     sal_sync;
  logic [DW-1:0]     tbl_rd;
  logic              tbl_we;

  // Writes only land while idle, so a running sequence never sees its table change.
  assign tbl_we = bus.cfg_we && (state == IDLE);

  count_cmd_table u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (step_q),
    .rdata (tbl_rd)
  );

  // Two-flop synchronizer for the asynchronous responder count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sal_meta <= '0;
      sal_sync <= '0;
    end else begin
      sal_meta <= bus.sal;
      sal_sync <= sal_meta;
    end
  end

  // State, step index, latched configuration and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step_q <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      tmo_q  <= '0;
    end else begin
      state  <= state_nxt;
      step_q <= step_nxt;
      last_q <= last_nxt;
      loop_q <= loop_nxt;
      tmo_q  <= tmo_nxt;
    end
  end

  // Next-state logic; a match at the final timeout cycle still wins over ERR,
  // and ERR begins once the counter would reach TIMEOUT.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_q;
    last_nxt  = last_q;
    loop_nxt  = loop_q;
    tmo_nxt   = tmo_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          step_nxt  = '0;
          last_nxt  = bus.cfg_last;
          loop_nxt  = bus.loop_en;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        tmo_nxt = tmo_q + TMO_W'(1);
        if ((tmo_q >= TMO_W'(BLANK)) && (sal_sync == tbl_rd)) begin
          state_nxt = NEXT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      NEXT: begin
        if (step_q < last_q) begin
          step_nxt  = step_q + TBL_AW'(1);
          state_nxt = ISSUE;
        end else if (loop_q) begin
          step_nxt  = '0;
          state_nxt = ISSUE;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ini      = (state == ISSUE);
  assign bus.ent      = ((state == ISSUE) || (state == WAIT)) ? tbl_rd : '0;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.err      = (state == ERR);
  assign bus.step_idx = step_q;

endmodule

// File: doc/count_commander.md
COUNT_COMMANDER -- requirements
Module: count_commander

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 The block SHALL expose `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL expose `start`, input, 1 bit: launch a sequence; sampled only in IDLE.
REQ-004 The block SHALL expose `loop_en`, input, 1 bit: restart at entry 0 after the last entry instead of finishing.
REQ-005 The block SHALL expose `cfg_we`, input, 1 bit: target-table write strobe.
REQ-006 The block SHALL expose `cfg_addr`, input, 3 bits: target-table index 0..7.
REQ-007 The block SHALL expose `cfg_data`, input, 4 bits: target value.
REQ-008 The block SHALL expose `cfg_last`, input, 3 bits: index of the last entry in the sequence; sequence length is cfg_last+1.
REQ-009 The block SHALL expose `ini`, output, 1 bit: load pulse to the counting responder.
REQ-010 The block SHALL expose `ent`, output, 4 bits: target presented to the responder.
REQ-011 The block SHALL expose `sal`, input, 4 bits: responder count value, treated as asynchronous.
REQ-012 The block SHALL expose `busy`, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL expose `done`, output, 1 bit: one-cycle pulse when a non-looping sequence completes.
REQ-014 The block SHALL expose `err`, output, 1 bit: sticky timeout flag.
REQ-015 The block SHALL expose `step_idx`, output, 3 bits: index of the entry currently being issued.

Function
REQ-016 `sal` SHALL pass through a 2-flop synchronizer before any comparison.
REQ-017 The FSM states SHALL be IDLE, ISSUE, WAIT, NEXT, DONE and ERR.
REQ-018 In IDLE, `start`=1 SHALL cause: `step_idx`<=0, latch `cfg_last` and `loop_en`, go to ISSUE.
REQ-019 In IDLE, `start`=0 SHALL hold the FSM in IDLE.
REQ-020 ISSUE SHALL last exactly 1 cycle, with `ini`=1 and `ent`=table[`step_idx`], then go to WAIT.
REQ-021 `ent` SHALL hold table[`step_idx`] through ISSUE and WAIT, and SHALL be 0 in all other states.
REQ-022 WAIT SHALL clear a 5-bit timeout counter on entry, then increment it every cycle.
REQ-023 WAIT SHALL ignore comparisons while the timeout counter is below 3 (stale-`sal` blanking).
REQ-024 After blanking, synchronized `sal`==`ent` SHALL move WAIT to NEXT.
REQ-025 If the timeout counter reaches 24 without a match, WAIT SHALL go to ERR; a match on that same cycle takes priority.
REQ-026 In NEXT (1 cycle), if `step_idx`<last, `step_idx` SHALL increment and the FSM SHALL go to ISSUE.
REQ-027 In NEXT with `step_idx`==last and latched `loop_en`=1, `step_idx` SHALL become 0 and the FSM SHALL go to ISSUE.
REQ-028 In NEXT with `step_idx`==last and latched `loop_en`=0, the FSM SHALL go to DONE.
REQ-029 DONE SHALL last 1 cycle with `done`=1, then go to IDLE.
REQ-030 ERR SHALL set `err`=1, drive `ini`=0, and remain in ERR until `rst`.
REQ-031 A table write SHALL take effect only when `cfg_we`=1 and `busy`=0.
REQ-032 A table write attempted while `busy`=1 SHALL be ignored.
REQ-033 When `start` and `cfg_we` are both asserted in IDLE, the write SHALL commit at that edge, and the first ISSUE SHALL use the new value.
REQ-034 `cfg_last`=0 SHALL give a single-entry sequence.
REQ-035 A target of 0 SHALL complete once blanking ends.

Reset
REQ-036 When `rst`=1 at a rising edge, the FSM SHALL go to IDLE.
REQ-037 On reset, `ini`, `ent`, `busy`, `done`, `err` and `step_idx` SHALL all be 0.
REQ-038 On reset, all 8 table entries, the timeout counter and the synchronizer flops SHALL be 0.
REQ-039 Reset SHALL take priority over all other inputs and SHALL abort a sequence in progress with no `done` pulse.

Structure
REQ-040 The shared package count_cmd_pkg SHALL hold the state enum and the constants TBL_DEPTH=8, TBL_AW=3, DW=4, BLANK=3, TIMEOUT=24.
REQ-041 The 8x4 target table SHALL be a sub-module count_cmd_table, with 1 write port and 1 combinational read port.

Verification
REQ-042 The bench SHALL use a behavioural responder model: it counts from 0 toward the latched target on the falling edge, and the latch happens when `ini`=1.
REQ-043 Scenario — basic: table={3,7,0}, `cfg_last`=2, `start` -> `ent` sequence 3,7,0, one `ini` pulse per entry, `done` pulse once, `busy` low after.
REQ-044 Scenario — loop: table={2}, `cfg_last`=0, `loop_en`=1 -> `ini` repeats indefinitely, `done` never asserts, `step_idx` stays 0.
REQ-045 Scenario — timeout: responder held in reset, target 5 -> `err`=1 exactly 24 cycles after WAIT entry; `err` stays set until `rst`.
REQ-046 Scenario — busy write: `cfg_we` to address 1 with data F while `busy` -> table[1] unchanged.
REQ-047 Scenario — simultaneous write: `start` together with a write of 9 to address 0 -> first `ent`=9.
REQ-048 Scenario — reset mid-operation: `rst` asserted during WAIT of entry 1 -> all outputs 0 next cycle, no `done`, table cleared.
